regfile_wb_arbiter: RTL and testbench

Write-back arbiter and sequencer for the 16×32 register file. It shares the single general write port (wEn1/wA1/wD1) among NREQ requesters (ALU, load unit, debug/config) using round-robin priority. It also owns the dedicated r15 port (wEn15/wDr15) and merges fetch PC updates with architectural writes to r15. All regfile write signals are registered, so the regfile sees one clean write per port per cycle.

---
 rtl/regfile_pkg.sv | 28 ++
 rtl/regfile_wb_arbiter_rr.sv | 43 ++++
 rtl/regfile_wb_arbiter.sv | 98 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-back path.
// Holds the round-robin pick helper used by the arbiter.
package regfile_pkg;

  localparam int unsigned AW      = 4;
  localparam int unsigned DW      = 32;
  localparam int unsigned NREGS   = 16;
  localparam logic [3:0]  PC_REG  = 4'd15;
  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned MAX_PW  = 3;

  // First valid requester at or after ptr, circular over nreq entries; one-hot or zero.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [MAX_PW-1:0]  ptr,
                                                 input int unsigned        nreq);
    logic [MAX_REQ-1:0] grant;
    logic [MAX_PW-1:0]  idx;
    grant = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = MAX_PW'((32'(ptr) + i) % nreq);
      if ((i < nreq) && (grant == '0) && valid[idx]) begin
        grant[idx] = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Round-robin grant over NREQ requesters with a registered rotation pointer.
// The grant is combinational; the pointer advances past each granted requester.
module rr_arbiter #(
  parameter int unsigned NREQ = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] valid,
  input  logic            hold,
  output logic [NREQ-1:0] grant_c
);
  import regfile_pkg::*;

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      ptr_next;
  logic [MAX_REQ-1:0] pick;
  logic               unused_pick;

  // Grant selection and pointer advance.
  always_comb begin
    pick     = rr_pick(MAX_REQ'(valid), MAX_PW'(rr_ptr), NREQ);
    grant_c  = (rst || hold) ? '0 : pick[NREQ-1:0];
    ptr_next = rr_ptr;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_c[i]) begin
        ptr_next = PW'((i + 1) % NREQ);
      end
    end
  end

  assign unused_pick = ^pick;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else begin
      rr_ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the 16x32 register file: shares the general write port,
// redirects r15 writes to the dedicated port and merges fetch PC updates behind them.
module regfile_wb_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 4,
  parameter int unsigned DW   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               wb_hold,
  input  logic               pc_we,
  input  logic [DW-1:0]      pc_next,
  output logic               pc_stall,
  output logic               wEn1,
  output logic [AW-1:0]      wA1,
  output logic [DW-1:0]      wD1,
  output logic               wEn15,
  output logic [DW-1:0]      wDr15,
  output logic [15:0]        busy_mask
);
  import regfile_pkg::*;

  logic [NREQ-1:0]  grant_c;
  logic [AW-1:0]    sel_addr_c;
  logic [DW-1:0]    sel_data_c;
  logic             xfer_c;
  logic             redirect_c;
  logic             gen_c;
  logic [NREGS-1:0] busy_next_c;
  logic             wen1_q;
  logic             wen15_q;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   (req_valid),
    .hold    (wb_hold),
    .grant_c (grant_c)
  );

  assign req_ready = grant_c;

  // Mux the granted requester's payload and classify the transfer.
  always_comb begin
    sel_addr_c = '0;
    sel_data_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_c[i]) begin
        sel_addr_c = req_addr[i*AW +: AW];
        sel_data_c = req_data[i*DW +: DW];
      end
    end
    xfer_c      = |grant_c;
    redirect_c  = xfer_c && (sel_addr_c == AW'(PC_REG));
    gen_c       = xfer_c && !redirect_c;
    pc_stall    = pc_we && redirect_c;
    busy_next_c = '0;
    if (redirect_c) begin
      busy_next_c = NREGS'(1) << PC_REG;
    end else if (gen_c) begin
      busy_next_c = NREGS'(1) << sel_addr_c;
    end
  end

  // Stage register; the architectural r15 write takes priority over fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      wen1_q    <= 1'b0;
      wA1       <= '0;
      wD1       <= '0;
      wen15_q   <= 1'b0;
      wDr15     <= '0;
      busy_mask <= '0;
    end else begin
      wen1_q <= gen_c;
      if (gen_c) begin
        wA1 <= sel_addr_c;
        wD1 <= sel_data_c;
      end
      wen15_q <= redirect_c || pc_we;
      if (redirect_c) begin
        wDr15 <= sel_data_c;
      end else if (pc_we) begin
        wDr15 <= pc_next;
      end
      busy_mask <= busy_next_c;
    end
  end

  // A reset arriving while a write is staged must stop that write reaching the regfile.
  assign wEn1  = wen1_q && !rst;
  assign wEn15 = wen15_q && !rst;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a behavioural 16x32 regfile on its write ports.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [11:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        wb_hold;
  logic        pc_we;
  logic [31:0] pc_next;
  logic        pc_stall;
  logic        wEn1;
  logic [3:0]  wA1;
  logic [31:0] wD1;
  logic        wEn15;
  logic [31:0] wDr15;
  logic [15:0] busy_mask;

  logic [31:0] rf [16];
  int          n_checks = 0;
  int          n_fail   = 0;

  regfile_wb_arbiter #(.NREQ(3), .AW(4), .DW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wb_hold   (wb_hold),
    .pc_we     (pc_we),
    .pc_next   (pc_next),
    .pc_stall  (pc_stall),
    .wEn1      (wEn1),
    .wA1       (wA1),
    .wD1       (wD1),
    .wEn15     (wEn15),
    .wDr15     (wDr15),
    .busy_mask (busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file consuming the arbiter's write ports.
  always @(posedge clk) begin
    if (wEn1) rf[wA1] <= wD1;
    if (wEn15) rf[15] <= wDr15;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [31:0] d);
    req_addr[i*4 +: 4]  = a;
    req_data[i*32 +: 32] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    wb_hold   = 1'b0;
    pc_we     = 1'b0;
    pc_next   = '0;
    req_valid = 3'b111;
    req_addr  = '0;
    req_data  = '0;
    set_req(0, 4'd1, 32'h0000_00A1);
    set_req(1, 4'd2, 32'h0000_00A2);
    set_req(2, 4'd3, 32'h0000_00A3);
    for (int i = 0; i < 16; i++) rf[i] = '0;

    // Reset held for three cycles with every requester valid.
    tick(); tick(); tick();
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_wEn1", 32'(wEn1), 32'h0);
    check("rst_wEn15", 32'(wEn15), 32'h0);
    check("rst_busy", 32'(busy_mask), 32'h0);
    check("rst_wA1", 32'(wA1), 32'h0);

    // Round-robin with all three valid: grants 0,1,2,0,1,2.
    rst = 1'b0;
    #1;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("rr_ready_%0d", k), 32'(req_ready), 32'(3'b001 << (k % 3)));
      tick();
      check($sformatf("rr_wEn1_%0d", k), 32'(wEn1), 32'h1);
      check($sformatf("rr_wA1_%0d", k), 32'(wA1), 32'((k % 3) + 1));
      check($sformatf("rr_wD1_%0d", k), wD1, 32'hA1 + 32'(k % 3));
      check($sformatf("rr_busy_%0d", k), 32'(busy_mask), 32'(16'h1 << ((k % 3) + 1)));
    end
    req_valid = 3'b000;
    #1;
    check("idle_ready", 32'(req_ready), 32'h0);

    // r15 write from req1 collides with a fetch PC update.
    set_req(1, 4'd15, 32'h0000_1000);
    req_valid = 3'b010;
    pc_we     = 1'b1;
    pc_next   = 32'h0000_0044;
    #1;
    check("r15_ready", 32'(req_ready), 32'h2);
    check("r15_pc_stall", 32'(pc_stall), 32'h1);
    tick();
    check("r15_wEn15", 32'(wEn15), 32'h1);
    check("r15_wDr15", wDr15, 32'h0000_1000);
    check("r15_wEn1", 32'(wEn1), 32'h0);
    check("r15_busy", 32'(busy_mask), 32'h8000);
    req_valid = 3'b000;
    #1;
    check("retry_pc_stall", 32'(pc_stall), 32'h0);
    tick();
    check("retry_wEn15", 32'(wEn15), 32'h1);
    check("retry_wDr15", wDr15, 32'h0000_0044);
    check("retry_busy", 32'(busy_mask), 32'h0);
    check("r15_rf_arch", rf[15], 32'h0000_1000);
    pc_we = 1'b0;
    tick();
    check("r15_rf_pc", rf[15], 32'h0000_0044);
    check("pc_idle_wEn15", 32'(wEn15), 32'h0);

    // Hold with req0 and req2 valid; pointer sits at req2 and must not move.
    wb_hold   = 1'b1;
    req_valid = 3'b101;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("hold_ready_%0d", k), 32'(req_ready), 32'h0);
      tick();
      check($sformatf("hold_wEn1_%0d", k), 32'(wEn1), 32'h0);
    end
    wb_hold = 1'b0;
    #1;
    check("unhold_ready", 32'(req_ready), 32'h4);
    tick();
    check("unhold_wEn1", 32'(wEn1), 32'h1);
    check("unhold_wA1", 32'(wA1), 32'h3);
    check("unhold_next_ready", 32'(req_ready), 32'h1);
    req_valid = 3'b000;

    // Read-after-write of r5 through req0.
    set_req(0, 4'd5, 32'hDEAD_BEEF);
    req_valid = 3'b001;
    #1;
    check("raw_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 3'b000;
    check("raw_busy", 32'(busy_mask), 32'h0020);
    check("raw_wEn1", 32'(wEn1), 32'h1);
    tick();
    check("raw_rd1", rf[5], 32'hDEAD_BEEF);
    check("raw_busy_clear", 32'(busy_mask), 32'h0);

    // Establish r6, then have reset kill a staged overwrite.
    set_req(1, 4'd6, 32'h1111_1111);
    req_valid = 3'b010;
    #1;
    check("pre_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 3'b000;
    tick();
    check("pre_rf6", rf[6], 32'h1111_1111);
    set_req(2, 4'd6, 32'h2222_2222);
    req_valid = 3'b100;
    #1;
    check("mid_ready", 32'(req_ready), 32'h4);
    tick();
    rst       = 1'b1;
    req_valid = 3'b000;
    #1;
    check("mid_wEn1_gated", 32'(wEn1), 32'h0);
    tick();
    rst = 1'b0;
    check("mid_rf6", rf[6], 32'h1111_1111);
    check("mid_busy", 32'(busy_mask), 32'h0);

    // After reset the pointer is back at req0.
    req_valid = 3'b110;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'h2);
    req_valid = 3'b111;
    #1;
    check("post_rst_req0", 32'(req_ready), 32'h1);
    tick();
    check("post_rst_wA1", 32'(wA1), 32'h5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
